// File: rtl/cpu_step_ctrl.sv
// Run/step/breakpoint controller: debounces the run and step keys and issues a
// gated cpu_clk at half the mem_clk rate, counting every rising edge it issues.
module cpu_step_ctrl #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 32
) (
   input  logic             mem_clk,
   input  logic             resetn,
   input  logic             key_run_n,
   input  logic             key_step_n,
   input  logic             bp_en,
   input  logic [31:0]      bp_addr,
   input  logic [31:0]      pc,
   output logic             cpu_clk,
   output logic [1:0]       state,
   output logic             bp_hit,
   output logic [CNT_W-1:0] cycle_cnt
);

   localparam int                DB_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [DB_W-1:0]   DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam int                KEY_RUN  = 0;
   localparam int                KEY_STEP = 1;

   typedef enum logic [1:0] {
      ST_HALT = 2'b00,
      ST_RUN  = 2'b01,
      ST_STEP = 2'b10
   } state_t;

   // Key pipeline, one bit per key (bit 0 run, bit 1 step); levels are active-low.
   logic [1:0]            sync1_q, sync1_d;
   logic [1:0]            sync2_q, sync2_d;
   logic [1:0]            lvl_q, lvl_d;
   logic [1:0]            lvl_dly_q, lvl_dly_d;
   logic [1:0]            evt_q, evt_d;
   logic [1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
   logic                  run_evt, step_evt;

   state_t                state_q, state_d;
   logic                  cpu_clk_q, cpu_clk_d;
   logic                  bp_hit_q, bp_hit_d;
   logic                  step_pending_q, step_pending_d;
   logic                  skip_bp_q, skip_bp_d;
   logic [CNT_W-1:0]      cycle_cnt_q, cycle_cnt_d;
   logic                  bp_stop, fire, rise;

   // NOTE: every signal written in an always_comb gets a default first, so no
   // path through the block can leave a value held and infer a latch.
   always_comb begin
      sync1_d   = {key_step_n, key_run_n};
      sync2_d   = sync1_q;
      lvl_d     = lvl_q;
      db_cnt_d  = '0;
      for (int k = 0; k < 2; k++) begin
         if (sync2_q[k] != lvl_q[k]) begin
            if (db_cnt_q[k] == DB_LAST) begin
               lvl_d[k] = sync2_q[k];
            end else begin
               db_cnt_d[k] = db_cnt_q[k] + DB_W'(1);
            end
         end
      end
      lvl_dly_d = lvl_q;
      // Pulse only on released -> pressed; a release is silent.
      evt_d     = lvl_dly_q & ~lvl_q;
   end

   assign run_evt  = evt_q[KEY_RUN];
   assign step_evt = evt_q[KEY_STEP];

   always_comb begin
      state_d        = state_q;
      bp_hit_d       = bp_hit_q;
      step_pending_d = step_pending_q;
      skip_bp_d      = skip_bp_q;
      cycle_cnt_d    = cycle_cnt_q;

      bp_stop = bp_en && (pc == bp_addr) && !cpu_clk_q && !skip_bp_q;
      fire    = ((state_q == ST_RUN)  && !bp_stop) ||
                ((state_q == ST_STEP) && step_pending_q);
      // A high phase always completes; a rise is only issued from the low phase.
      rise      = !cpu_clk_q && fire;
      cpu_clk_d = rise;

      if (rise) begin
         cycle_cnt_d    = cycle_cnt_q + CNT_W'(1);
         skip_bp_d      = 1'b0;
         step_pending_d = 1'b0;
      end

      unique case (state_q)
         ST_HALT: begin
            if (run_evt) begin
               state_d   = ST_RUN;
               bp_hit_d  = 1'b0;
               skip_bp_d = 1'b1;
            end else if (step_evt) begin
               state_d        = ST_STEP;
               step_pending_d = 1'b1;
               bp_hit_d       = 1'b0;
               skip_bp_d      = 1'b1;
            end
         end
         ST_RUN: begin
            if (bp_stop) begin
               state_d  = ST_HALT;
               bp_hit_d = 1'b1;
            end else if (run_evt) begin
               state_d = ST_HALT;
            end
         end
         ST_STEP: begin
            // The single pulse has been issued; go back on its falling edge.
            if (cpu_clk_q && !step_pending_q) begin
               state_d = ST_HALT;
            end
         end
         default: state_d = ST_HALT;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the values from before the edge, independent of statement order.
   always_ff @(posedge mem_clk) begin
      if (!resetn) begin
         sync1_q        <= 2'b11;
         sync2_q        <= 2'b11;
         lvl_q          <= 2'b11;
         lvl_dly_q      <= 2'b11;
         evt_q          <= 2'b00;
         db_cnt_q       <= '0;
         state_q        <= ST_HALT;
         cpu_clk_q      <= 1'b0;
         bp_hit_q       <= 1'b0;
         step_pending_q <= 1'b0;
         skip_bp_q      <= 1'b0;
         cycle_cnt_q    <= '0;
      end else begin
         sync1_q        <= sync1_d;
         sync2_q        <= sync2_d;
         lvl_q          <= lvl_d;
         lvl_dly_q      <= lvl_dly_d;
         evt_q          <= evt_d;
         db_cnt_q       <= db_cnt_d;
         state_q        <= state_d;
         cpu_clk_q      <= cpu_clk_d;
         bp_hit_q       <= bp_hit_d;
         step_pending_q <= step_pending_d;
         skip_bp_q      <= skip_bp_d;
         cycle_cnt_q    <= cycle_cnt_d;
      end
   end

   assign cpu_clk   = cpu_clk_q;
   assign state     = state_q;
   assign bp_hit    = bp_hit_q;
   assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Bench for cpu_step_ctrl: directed scenarios plus random key/breakpoint traffic,
// every cycle compared against a behavioural model of the controller.
module tb_cpu_step_ctrl;

   localparam int DB = 4;

   logic        mem_clk = 1'b0;
   logic        resetn  = 1'b0;
   logic        key_run_n  = 1'b1;
   logic        key_step_n = 1'b1;
   logic        bp_en   = 1'b0;
   logic [31:0] bp_addr = 32'h0;
   logic [31:0] pc      = 32'h0;

   logic        cpu_clk, bp_hit, cpu_clk4, bp_hit4;
   logic [1:0]  state, state4;
   logic [31:0] cycle_cnt;
   logic [3:0]  cycle_cnt4;

   int n_checks = 0;
   int n_errors = 0;

   always #5 mem_clk = ~mem_clk;

   cpu_step_ctrl #(.DEBOUNCE_CYCLES(DB), .CNT_W(32)) dut (
      .mem_clk(mem_clk), .resetn(resetn), .key_run_n(key_run_n), .key_step_n(key_step_n),
      .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .cpu_clk(cpu_clk), .state(state),
      .bp_hit(bp_hit), .cycle_cnt(cycle_cnt)
   );

   cpu_step_ctrl #(.DEBOUNCE_CYCLES(DB), .CNT_W(4)) dut4 (
      .mem_clk(mem_clk), .resetn(resetn), .key_run_n(key_run_n), .key_step_n(key_step_n),
      .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .cpu_clk(cpu_clk4), .state(state4),
      .bp_hit(bp_hit4), .cycle_cnt(cycle_cnt4)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Keys: index 0 = run, 1 = step. Debounced levels are raw (1 = released).
   logic        m_s1[2], m_s2[2], m_lvl[2], m_lvl_dly[2], m_evt[2];
   int          m_run[2];
   int          m_mode;          // 0 halt, 1 run, 2 step
   logic        m_clk, m_hit, m_pend, m_skip;
   logic [31:0] m_cnt;

   task automatic model_edge();
      logic raw[2];
      logic run_e, step_e, stop, rose, old_clk, old_pend;
      raw[0] = key_run_n;
      raw[1] = key_step_n;
      if (!resetn) begin
         for (int k = 0; k < 2; k++) begin
            m_s1[k] = 1'b1; m_s2[k] = 1'b1; m_lvl[k] = 1'b1; m_lvl_dly[k] = 1'b1;
            m_evt[k] = 1'b0; m_run[k] = 0;
         end
         m_mode = 0; m_clk = 1'b0; m_hit = 1'b0; m_pend = 1'b0; m_skip = 1'b0;
         m_cnt = 32'd0;
         return;
      end
      run_e  = m_evt[0];
      step_e = m_evt[1];
      for (int k = 0; k < 2; k++) begin
         m_evt[k]     = (m_lvl[k] == 1'b0) && (m_lvl_dly[k] == 1'b1);
         m_lvl_dly[k] = m_lvl[k];
         if (m_s2[k] != m_lvl[k]) begin
            m_run[k]++;
            if (m_run[k] == DB) begin
               m_lvl[k] = m_s2[k];
               m_run[k] = 0;
            end
         end else begin
            m_run[k] = 0;
         end
         m_s2[k] = m_s1[k];
         m_s1[k] = raw[k];
      end
      old_clk  = m_clk;
      old_pend = m_pend;
      stop = bp_en && (pc == bp_addr) && !old_clk && !m_skip;
      rose = !old_clk && ((m_mode == 1 && !stop) || (m_mode == 2 && old_pend));
      m_clk = rose;
      if (rose) begin
         m_cnt  = m_cnt + 32'd1;
         m_skip = 1'b0;
         m_pend = 1'b0;
      end
      case (m_mode)
         0: if (run_e) begin
               m_mode = 1; m_hit = 1'b0; m_skip = 1'b1;
            end else if (step_e) begin
               m_mode = 2; m_pend = 1'b1; m_hit = 1'b0; m_skip = 1'b1;
            end
         1: if (stop) begin
               m_mode = 0; m_hit = 1'b1;
            end else if (run_e) begin
               m_mode = 0;
            end
         default: if (old_clk && !old_pend) m_mode = 0;
      endcase
   endtask

   always @(posedge mem_clk) model_edge();

   // ---------------- stimulus helpers ----------------
   logic prev_clk   = 1'b0;
   logic pc_jump_en = 1'b0;
   int   hi_cnt     = 0;
   int   nonhalt_cnt = 0;

   task automatic tick();
      @(posedge mem_clk);
      @(negedge mem_clk);
      check("state",     state,      64'(m_mode));
      check("cpu_clk",   cpu_clk,    m_clk);
      check("bp_hit",    bp_hit,     m_hit);
      check("cycle_cnt", cycle_cnt,  m_cnt);
      check("state4",    state4,     64'(m_mode));
      check("cpu_clk4",  cpu_clk4,   m_clk);
      check("bp_hit4",   bp_hit4,    m_hit);
      check("cnt4",      cycle_cnt4, m_cnt[3:0]);
      if (cpu_clk) hi_cnt++;
      if (state != 2'b00) nonhalt_cnt++;
      // Emulated CPU: the PC advances on each cpu_clk rise, sometimes jumping to 0.
      if (cpu_clk && !prev_clk) begin
         if (pc_jump_en && $urandom_range(0, 19) == 0) pc = 32'h0;
         else                                          pc = pc + 32'd4;
      end
      prev_clk = cpu_clk;
   endtask

   task automatic do_reset(input int n);
      resetn = 1'b0;
      key_run_n = 1'b1;
      key_step_n = 1'b1;
      repeat (n) tick();
      pc = 32'h0;
      resetn = 1'b1;
   endtask

   task automatic press(input logic do_run, input logic do_step, input int hold);
      if (do_run)  key_run_n  = 1'b0;
      if (do_step) key_step_n = 1'b0;
      repeat (hold) tick();
      key_run_n  = 1'b1;
      key_step_n = 1'b1;
      repeat (DB + 6) tick();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      do_reset(3);
      check("rst_state", state, 2'b00);
      check("rst_clk",   cpu_clk, 1'b0);
      check("rst_cnt",   cycle_cnt, 32'd0);
      check("rst_hit",   bp_hit, 1'b0);

      // Bouncing run key, never low for DB consecutive samples: no event
      hi_cnt = 0; nonhalt_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         key_run_n = (i % 2 == 1);
         tick();
      end
      key_run_n = 1'b1;
      repeat (12) tick();
      check("bounce_nonhalt", 32'(nonhalt_cnt), 32'd0);
      check("bounce_clk_hi",  32'(hi_cnt), 32'd0);

      // Steady run press: event DB+3 edges in, state one edge later, rise one more
      key_run_n = 1'b0;
      repeat (DB + 3) tick();
      check("run_lat_pre", state, 2'b00);
      tick();
      check("run_lat",     state, 2'b01);
      check("run_clk_lo",  cpu_clk, 1'b0);
      tick();
      check("run_first_rise", cpu_clk, 1'b1);
      check("run_first_cnt",  cycle_cnt, 32'd1);
      key_run_n = 1'b1;
      for (int i = 0; i < 100 && m_cnt != 32'd20; i++) tick();
      check("run20_reached", m_cnt, 32'd20);
      check("run20_cnt", cycle_cnt, 32'd20);
      hi_cnt = 0;
      repeat (10) tick();
      check("run_duty", 32'(hi_cnt), 32'd5);
      press(1'b1, 1'b0, 12);
      check("halt_state", state, 2'b00);
      check("halt_clk",   cpu_clk, 1'b0);

      // Three single steps
      do_reset(2);
      hi_cnt = 0;
      for (int s = 0; s < 3; s++) begin
         press(1'b0, 1'b1, 12);
         check("step_back_halt", state, 2'b00);
      end
      check("step_pulses", 32'(hi_cnt), 32'd3);
      check("step_cnt", cycle_cnt, 32'd3);

      // Breakpoint at 0x10, then resume past it
      do_reset(2);
      bp_en = 1'b1;
      bp_addr = 32'h10;
      press(1'b1, 1'b0, 12);
      check("bp_state", state, 2'b00);
      check("bp_hit_set", bp_hit, 1'b1);
      check("bp_cnt", cycle_cnt, 32'd4);
      check("bp_pc", pc, 32'h10);
      key_run_n = 1'b0;
      for (int i = 0; i < 40 && m_cnt != 32'd5; i++) tick();
      check("resume_reached", m_cnt, 32'd5);
      check("resume_hit_clr", bp_hit, 1'b0);
      check("resume_cnt", cycle_cnt, 32'd5);
      key_run_n = 1'b1;
      repeat (15) tick();
      check("resume_running", state, 2'b01);
      press(1'b1, 1'b0, 12);
      bp_en = 1'b0;

      // Simultaneous run and step in HALT: run wins
      key_run_n = 1'b0;
      key_step_n = 1'b0;
      repeat (DB + 4) tick();
      check("both_run", state, 2'b01);
      key_run_n = 1'b1;
      key_step_n = 1'b1;
      repeat (10) tick();
      check("both_still_run", state, 2'b01);
      press(1'b1, 1'b0, 12);

      // Reset in the middle of a high phase
      key_run_n = 1'b0;
      for (int i = 0; i < 40 && !(m_mode == 1 && m_clk); i++) tick();
      check("midhi_reached", m_clk, 1'b1);
      resetn = 1'b0;
      key_run_n = 1'b1;
      tick();
      check("midhi_clk",   cpu_clk, 1'b0);
      check("midhi_state", state, 2'b00);
      check("midhi_cnt",   cycle_cnt, 32'd0);
      resetn = 1'b1;
      pc = 32'h0;
      repeat (3) tick();

      // 4-bit counter wraps after 16 rises
      key_run_n = 1'b0;
      for (int i = 0; i < 80 && m_cnt != 32'd16; i++) tick();
      check("wrap_reached", m_cnt, 32'd16);
      check("wrap_cnt4", cycle_cnt4, 4'd0);
      check("wrap_cnt32", cycle_cnt, 32'd16);
      key_run_n = 1'b1;
      repeat (10) tick();
      press(1'b1, 1'b0, 12);

      // Random traffic: bouncy keys, moving breakpoint, PC jumps, rare resets
      begin
         int rem_run = 0;
         int rem_step = 0;
         pc_jump_en = 1'b1;
         for (int i = 0; i < 2000; i++) begin
            if (rem_run == 0) begin
               key_run_n = 1'($urandom_range(0, 1));
               rem_run = $urandom_range(1, 20);
            end
            if (rem_step == 0) begin
               key_step_n = 1'($urandom_range(0, 1));
               rem_step = $urandom_range(1, 20);
            end
            rem_run--;
            rem_step--;
            if (i % 200 == 0) begin
               bp_en = 1'($urandom_range(0, 1));
               bp_addr = 32'(4 * $urandom_range(0, 15));
            end
            if ($urandom_range(0, 499) == 0) begin
               resetn = 1'b0;
               tick();
               pc = 32'h0;
               resetn = 1'b1;
            end else begin
               tick();
            end
         end
         pc_jump_en = 1'b0;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
